// File: rtl/shift_sequencer.sv
// shift_fifo: first-word-fall-through result buffer for the shift sequencer.
// Latency: a pushed entry appears at the head the cycle after the push edge.
// Backpressure: caller must not push when full; pop of an empty FIFO is ignored.
module shift_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic         head_vld,
   output logic [W-1:0] head_dat,
   output logic         full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   // Head is taken straight from storage; zero when empty so idle outputs are quiet.
   always_comb begin
      head_vld = (count_q != '0);
      head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
      full     = (count_q == DEPTH_CNT);
      do_pop   = pop && head_vld;
   end

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Registered FIFO state; reset drops every entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// shift_sequencer: drives the shared 3-bit right shifters over several passes per command.
// Latency: k = max(1, ceil(amt/7)) SHIFT cycles after acceptance, result visible one cycle later.
// Backpressure: in_ready only in IDLE with a free FIFO slot reserved; out_* held until popped.
module shift_sequencer #(
   parameter int AMT_W     = 4,
   parameter int OUT_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [1:0]       in_op,
   output logic [7:0]       sh_in,
   output logic [2:0]       sh_b,
   input  logic [7:0]       rot_res,
   input  logic [7:0]       lsh_res,
   input  logic [7:0]       ash_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_err
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [1:0] OP_ROT = 2'b00;
   localparam logic [1:0] OP_LSH = 2'b01;
   localparam logic [1:0] OP_ASH = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   state_t           state_q, state_d;
   logic [7:0]       work_q, work_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [1:0]       op_q, op_d;

   logic [2:0]       step;
   logic [AMT_W-1:0] rem_next;
   logic [7:0]       sel;
   logic             accept;
   logic             push;
   logic [8:0]       push_dat;
   logic             fifo_full;
   logic             fifo_vld;
   logic [8:0]       fifo_head;

   // Per-pass amount, remaining amount after the pass, and the shifter result for the latched op.
   always_comb begin
      step     = (rem_q > AMT_W'(7)) ? 3'd7 : rem_q[2:0];
      rem_next = rem_q - AMT_W'(step);
      case (op_q)
         OP_ROT:  sel = rot_res;
         OP_LSH:  sel = lsh_res;
         OP_ASH:  sel = ash_res;
         default: sel = work_q;
      endcase
   end

   // Handshake and shifter drive; the reserved op passes through without shifting, so b stays 0.
   always_comb begin
      in_ready = (state_q == IDLE) && !fifo_full && !rst;
      accept   = in_valid && in_ready;
      sh_in    = work_q;
      sh_b     = ((state_q == SHIFT) && (op_q != OP_RSV)) ? step : 3'd0;
   end

   // Next-state and push decision: one pass per SHIFT cycle, push on the final pass.
   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      rem_d    = rem_q;
      op_d     = op_q;
      push     = 1'b0;
      push_dat = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               work_d  = in_data;
               rem_d   = in_amt;
               op_d    = in_op;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (op_q == OP_RSV) begin
               push     = 1'b1;
               push_dat = {work_q, 1'b1};
               rem_d    = '0;
               state_d  = IDLE;
            end else begin
               work_d = sel;
               rem_d  = rem_next;
               if (rem_next == '0) begin
                  push     = 1'b1;
                  push_dat = {sel, 1'b0};
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer registers; reset abandons any in-flight command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
      end
   end

   shift_fifo #(
      .W     (9),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_dat),
      .pop      (out_ready),
      .head_vld (fifo_vld),
      .head_dat (fifo_head),
      .full     (fifo_full)
   );

   // Head entry is {result, err}.
   always_comb begin
      out_valid = fifo_vld;
      out_data  = fifo_head[8:1];
      out_err   = fifo_head[0];
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with behavioural models of the three shifters.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic [3:0] in_amt = '0;
   logic [1:0] in_op = '0;
   logic [7:0] sh_in;
   logic [2:0] sh_b;
   logic [7:0] rot_res, lsh_res, ash_res;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_err;

   logic [15:0] rot_wide;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Shifter models: rotate, logical and arithmetic right by sh_b.
   assign rot_wide = {sh_in, sh_in} >> sh_b;
   assign rot_res  = rot_wide[7:0];
   assign lsh_res  = sh_in >> sh_b;
   assign ash_res  = $unsigned($signed(sh_in) >>> sh_b);

   shift_sequencer #(.AMT_W(4), .OUT_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .sh_in     (sh_in),
      .sh_b      (sh_b),
      .rot_res   (rot_res),
      .lsh_res   (lsh_res),
      .ash_res   (ash_res),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] amt;
      logic [1:0] op;
      logic [7:0] exp_data;
      logic       exp_err;
      logic [2:0] exp_b0;
      logic [3:0] exp_k;
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs [NVEC];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for in_ready, then presents one command for exactly the accepting edge.
   task automatic issue(input logic [7:0] d, input logic [3:0] a, input logic [1:0] o);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("issue_ready", {31'd0, in_ready}, 32'd1);
      in_data  = d;
      in_amt   = a;
      in_op    = o;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Counts edges after acceptance until out_valid rises, bounded.
   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int  n;
      bit  seen;

      //                data    amt  op     result err b0    k
      vecs[0] = '{8'hF0, 4'd3,  2'b00, 8'h1E, 1'b0, 3'd3, 4'd1};
      vecs[1] = '{8'hF0, 4'd3,  2'b01, 8'h1E, 1'b0, 3'd3, 4'd1};
      vecs[2] = '{8'hF0, 4'd3,  2'b10, 8'hFE, 1'b0, 3'd3, 4'd1};
      vecs[3] = '{8'hF0, 4'd9,  2'b00, 8'h78, 1'b0, 3'd7, 4'd2};
      vecs[4] = '{8'hF0, 4'd9,  2'b01, 8'h00, 1'b0, 3'd7, 4'd2};
      vecs[5] = '{8'hF0, 4'd15, 2'b10, 8'hFF, 1'b0, 3'd7, 4'd3};
      vecs[6] = '{8'hA5, 4'd0,  2'b01, 8'hA5, 1'b0, 3'd0, 4'd1};
      vecs[7] = '{8'hF0, 4'd5,  2'b11, 8'hF0, 1'b1, 3'd0, 4'd1};
      vecs[8] = '{8'h81, 4'd10, 2'b00, 8'h60, 1'b0, 3'd7, 4'd2};
      vecs[9] = '{8'h96, 4'd14, 2'b00, 8'h5A, 1'b0, 3'd7, 4'd2};

      // Reset state
      tick();
      tick();
      check("rst_in_ready",  {31'd0, in_ready},  32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  {24'd0, out_data},  32'd0);
      check("rst_out_err",   {31'd0, out_err},   32'd0);
      check("rst_sh_in",     {24'd0, sh_in},     32'd0);
      check("rst_sh_b",      {29'd0, sh_b},      32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Table-driven single commands
      out_ready = 1'b0;
      for (int i = 0; i < NVEC; i++) begin
         issue(vecs[i].data, vecs[i].amt, vecs[i].op);
         check($sformatf("v%0d_in_ready_drop", i), {31'd0, in_ready}, 32'd0);
         check($sformatf("v%0d_sh_b_first", i), {29'd0, sh_b}, {29'd0, vecs[i].exp_b0});
         wait_out(n);
         check($sformatf("v%0d_latency", i), n, {28'd0, vecs[i].exp_k});
         check($sformatf("v%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].exp_data});
         check($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
         check($sformatf("v%0d_in_ready_back", i), {31'd0, in_ready}, 32'd1);
         check($sformatf("v%0d_idle_sh_b", i), {29'd0, sh_b}, 32'd0);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         check($sformatf("v%0d_popped", i), {31'd0, out_valid}, 32'd0);
      end

      // Multi-pass step sequence for amt 15: 7, 7, 1
      issue(8'hF0, 4'd15, 2'b10);
      check("amt15_pass1_b", {29'd0, sh_b}, 32'd7);
      tick();
      check("amt15_pass2_b", {29'd0, sh_b}, 32'd7);
      check("amt15_pass2_in", {24'd0, sh_in}, 32'hFF);
      tick();
      check("amt15_pass3_b", {29'd0, sh_b}, 32'd1);
      tick();
      check("amt15_done", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Back-pressure: two results fill the FIFO, third command must wait for a pop
      issue(8'h10, 4'd1, 2'b01);
      wait_out(n);
      check("bp_a_latency", n, 32'd1);
      issue(8'h20, 4'd1, 2'b01);
      tick();
      check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
      in_data  = 8'h40;
      in_amt   = 4'd1;
      in_op    = 2'b01;
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("bp_blocked_%0d", c), {31'd0, in_ready}, 32'd0);
         check($sformatf("bp_hold_data_%0d", c), {24'd0, out_data}, 32'h08);
      end
      out_ready = 1'b1;
      #1;
      check("bp_pop_cycle_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      out_ready = 1'b0;
      check("bp_after_pop_in_ready", {31'd0, in_ready}, 32'd1);
      check("bp_after_pop_head", {24'd0, out_data}, 32'h10);
      tick();
      in_valid = 1'b0;
      check("bp_c_accepted", {31'd0, in_ready}, 32'd0);
      tick();
      out_ready = 1'b1;
      check("bp_drain_0", {24'd0, out_data}, 32'h10);
      tick();
      check("bp_drain_1", {24'd0, out_data}, 32'h20);
      check("bp_drain_1_vld", {31'd0, out_valid}, 32'd1);
      tick();
      out_ready = 1'b0;
      check("bp_drained", {31'd0, out_valid}, 32'd0);

      // Reset during the second pass of amt 15 with one entry buffered
      issue(8'h10, 4'd1, 2'b01);
      wait_out(n);
      check("rm_first_done", {31'd0, out_valid}, 32'd1);
      issue(8'hF0, 4'd15, 2'b10);
      tick();
      check("rm_second_pass", {29'd0, sh_b}, 32'd7);
      rst = 1'b1;
      tick();
      check("rm_out_valid", {31'd0, out_valid}, 32'd0);
      check("rm_sh_b", {29'd0, sh_b}, 32'd0);
      check("rm_sh_in", {24'd0, sh_in}, 32'd0);
      check("rm_in_ready_in_rst", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("rm_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      out_ready = 1'b0;
      check("rm_nothing_output", {31'd0, seen}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
